rf_access_arbiter: RTL

Shares the protected processor's 32×32 register file between three requesters:
- the single-cycle core datapath, which is the default owner;
- a debug port, for single-register read/write with a valid/ready handshake;
- a dump engine, which streams all 32 registers out for checkpoint and compare.

The block sits between the core and the register file. It drives the register file's address, data and write-enable inputs, and stalls the core on every cycle it steals the ports.

---
 rtl/rf_access_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rf_access_arbiter.sv
// Register-file port arbiter: core by default, debug single accesses, and a 32-word dump engine.
// Build option: define RF_ARB_DUMP_EN to include the dump engine; without it only IDLE/DBG/GAP exist.
module rf_access_arbiter #(
  parameter int DUMP_GAP = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [4:0]  core_rs1,
  input  logic [4:0]  core_rs2,
  input  logic [4:0]  core_rd,
  input  logic [31:0] core_wdata,
  input  logic        core_we,
  output logic [31:0] core_rdata1,
  output logic [31:0] core_rdata2,
  output logic        core_stall,
  output logic [4:0]  rf_read_addr1,
  output logic [4:0]  rf_read_addr2,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_write_enable,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2,
  input  logic        dbg_valid,
  input  logic        dbg_write,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  input  logic        dump_start,
  output logic        dump_busy,
  output logic        dump_valid,
  output logic [4:0]  dump_index,
  output logic [31:0] dump_data
);

`ifdef RF_ARB_DUMP_EN
  typedef enum logic [2:0] {IDLE, DBG, GAP, DUMP_RD, DUMP_WAIT} state_t;

  localparam logic [2:0] GAP_LOAD = (DUMP_GAP > 0) ? 3'(DUMP_GAP - 1) : 3'd0;

  logic [4:0] counter;
  logic [2:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, DBG, GAP} state_t;

  logic unused_dump;
  assign unused_dump = dump_start | (DUMP_GAP < 0);
  assign dump_busy   = 1'b0;
  assign dump_valid  = 1'b0;
  assign dump_index  = 5'd0;
  assign dump_data   = 32'd0;
`endif

  state_t state;

  assign rf_read_addr2 = core_rs2;
  assign core_rdata1   = rf_read_data1;
  assign core_rdata2   = rf_read_data2;

  // Port ownership is a pure decode of state; reset blocks every write to the file.
  always_comb begin
    core_stall      = 1'b0;
    dbg_ready       = 1'b0;
    rf_read_addr1   = core_rs1;
    rf_write_addr   = core_rd;
    rf_write_data   = core_wdata;
    rf_write_enable = core_we & rstN;
    case (state)
      DBG: begin
        core_stall      = 1'b1;
        dbg_ready       = 1'b1;
        rf_read_addr1   = dbg_addr;
        rf_write_addr   = dbg_addr;
        rf_write_data   = dbg_wdata;
        rf_write_enable = dbg_write & rstN;
      end
`ifdef RF_ARB_DUMP_EN
      DUMP_RD: begin
        core_stall      = 1'b1;
        rf_read_addr1   = counter;
        rf_write_enable = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= 32'd0;
`ifdef RF_ARB_DUMP_EN
      counter    <= 5'd0;
      gap_cnt    <= 3'd0;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_index <= 5'd0;
      dump_data  <= 32'd0;
`endif
    end else begin
      dbg_rvalid <= 1'b0;
`ifdef RF_ARB_DUMP_EN
      dump_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (dbg_valid) begin
            state <= DBG;
          end
`ifdef RF_ARB_DUMP_EN
          else if (dump_start) begin
            state     <= DUMP_RD;
            counter   <= 5'd0;
            dump_busy <= 1'b1;
          end
`endif
        end
        DBG: begin
          if (!dbg_write) begin
            dbg_rdata  <= rf_read_data1;
            dbg_rvalid <= 1'b1;
          end
          state <= GAP;
        end
        // One guaranteed unstalled core cycle after every debug access.
        GAP: state <= IDLE;
`ifdef RF_ARB_DUMP_EN
        DUMP_RD: begin
          dump_data  <= rf_read_data1;
          dump_index <= counter;
          dump_valid <= 1'b1;
          if (counter == 5'd31) begin
            state     <= IDLE;
            dump_busy <= 1'b0;
          end else begin
            counter <= counter + 5'd1;
            if (DUMP_GAP > 0) begin
              state   <= DUMP_WAIT;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        DUMP_WAIT: begin
          if (gap_cnt == 3'd0) state <= DUMP_RD;
          else                 gap_cnt <= gap_cnt - 3'd1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
